mem_stage_lsu: RTL and testbench

- MEM-stage load/store unit; consumes the EX/MEM pipeline-register outputs and acts as initiator on the data-memory bus (valid/ready request channel, valid response channel).
- Computes byte strobes and replicated write data for stores. Extracts and sign/zero-extends load data.
- Holds the pipeline via stall_o until each access completes; feeds the MEM/WB register with result_o.

---
 rtl/mem_stage_lsu.sv | 158 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit driving the data-memory bus
// Store strobes/replication, load extraction/extension, pipeline stall until each access completes.
package mem_stage_lsu_pkg;
   typedef enum logic [3:0] {
      LSU_NONE = 4'd0,
      LSU_LB   = 4'd1,
      LSU_LH   = 4'd2,
      LSU_LW   = 4'd3,
      LSU_LD   = 4'd4,
      LSU_LBU  = 4'd5,
      LSU_LHU  = 4'd6,
      LSU_LWU  = 4'd7,
      LSU_SB   = 4'd8,
      LSU_SH   = 4'd9,
      LSU_SW   = 4'd10,
      LSU_SD   = 4'd11
   } lsu_op_t;
endpackage

module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] alu_result_i,
   input  logic [63:0] store_data_i,
   input  lsu_op_t     lsu_op_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   output logic        dmem_req_valid_o,
   input  logic        dmem_req_ready_i,
   output logic [63:0] dmem_addr_o,
   output logic        dmem_we_o,
   output logic [63:0] dmem_wdata_o,
   output logic [7:0]  dmem_wstrb_o,
   input  logic        dmem_rsp_valid_i,
   input  logic [63:0] dmem_rdata_i,
   input  logic        dmem_rsp_err_i,
   output logic [63:0] result_o,
   output logic        stall_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

   state_t      state;
   logic [63:0] load_data_q;
   logic [31:0] cnt;

   logic [2:0]  off;
   logic [3:0]  size;
   logic [7:0]  mask;
   logic        misaligned;
   logic        mem_op;
   logic        timeout_hit;
   logic [63:0] shifted;
   logic [63:0] load_ext;

   assign off    = alu_result_i[2:0];
   assign mem_op = (mem_read_i | mem_write_i) && (lsu_op_i != LSU_NONE);

   always_comb begin
      size = 4'd0;
      mask = 8'h00;
      case (lsu_op_i)
         LSU_LB, LSU_LBU, LSU_SB: begin size = 4'd1; mask = 8'h01; end
         LSU_LH, LSU_LHU, LSU_SH: begin size = 4'd2; mask = 8'h03; end
         LSU_LW, LSU_LWU, LSU_SW: begin size = 4'd4; mask = 8'h0F; end
         LSU_LD, LSU_SD:          begin size = 4'd8; mask = 8'hFF; end
         default:                 begin size = 4'd0; mask = 8'h00; end
      endcase
   end

   always_comb begin
      case (size)
         4'd2:    misaligned = off[0];
         4'd4:    misaligned = (off[1:0] != 2'b00);
         4'd8:    misaligned = (off != 3'b000);
         default: misaligned = 1'b0;
      endcase
   end

   always_comb begin
      case (size)
         4'd1:    dmem_wdata_o = {8{store_data_i[7:0]}};
         4'd2:    dmem_wdata_o = {4{store_data_i[15:0]}};
         4'd4:    dmem_wdata_o = {2{store_data_i[31:0]}};
         default: dmem_wdata_o = store_data_i;
      endcase
   end

   assign dmem_req_valid_o = (state == S_REQ) || ((state == S_IDLE) && mem_op && !misaligned);
   assign dmem_addr_o      = {alu_result_i[63:3], 3'b000};
   assign dmem_we_o        = mem_write_i;
   assign dmem_wstrb_o     = mem_write_i ? (mask << off) : 8'h00;

   // A timeout only fires when no response arrives in the same cycle.
   assign timeout_hit = (TIMEOUT != 0) && (state == S_RESP) && !dmem_rsp_valid_i
                        && (cnt == TIMEOUT - 1);
   assign bus_err_o   = (state == S_RESP) && ((dmem_rsp_valid_i && dmem_rsp_err_i) || timeout_hit);
   assign misalign_o  = (state == S_IDLE) && mem_op && misaligned;
   assign stall_o     = dmem_req_valid_o || (state == S_RESP);

   assign shifted = load_data_q >> {off, 3'b000};

   always_comb begin
      case (lsu_op_i)
         LSU_LB:  load_ext = {{56{shifted[7]}},  shifted[7:0]};
         LSU_LH:  load_ext = {{48{shifted[15]}}, shifted[15:0]};
         LSU_LW:  load_ext = {{32{shifted[31]}}, shifted[31:0]};
         LSU_LBU: load_ext = {56'd0, shifted[7:0]};
         LSU_LHU: load_ext = {48'd0, shifted[15:0]};
         LSU_LWU: load_ext = {32'd0, shifted[31:0]};
         default: load_ext = shifted;
      endcase
   end

   assign result_o = ((state == S_DONE) && mem_read_i) ? load_ext : alu_result_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         load_data_q <= 64'd0;
         cnt         <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               cnt <= 32'd0;
               if (dmem_req_valid_o)
                  state <= dmem_req_ready_i ? S_RESP : S_REQ;
            end
            S_REQ: begin
               if (dmem_req_ready_i)
                  state <= S_RESP;
            end
            S_RESP: begin
               if (dmem_rsp_valid_i) begin
                  load_data_q <= dmem_rdata_i;
                  state       <= S_DONE;
               end else if (timeout_hit) begin
                  load_data_q <= 64'd0;
                  state       <= S_DONE;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            default: begin
               cnt   <= 32'd0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
// Vectors drive the bus handshake by hand; expected values are hand-computed.
module tb_mem_stage_lsu;
   import mem_stage_lsu_pkg::*;

   logic        clk;
   logic        rst;
   logic [63:0] alu_result;
   logic [63:0] store_data;
   lsu_op_t     lsu_op;
   logic        mem_read;
   logic        mem_write;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] addr;
   logic        we;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        rsp_valid;
   logic [63:0] rdata;
   logic        rsp_err;
   logic [63:0] result;
   logic        stall;
   logic        misalign;
   logic        bus_err;

   int checks = 0;
   int errors = 0;

   mem_stage_lsu #(.TIMEOUT(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .alu_result_i     (alu_result),
      .store_data_i     (store_data),
      .lsu_op_i         (lsu_op),
      .mem_read_i       (mem_read),
      .mem_write_i      (mem_write),
      .dmem_req_valid_o (req_valid),
      .dmem_req_ready_i (req_ready),
      .dmem_addr_o      (addr),
      .dmem_we_o        (we),
      .dmem_wdata_o     (wdata),
      .dmem_wstrb_o     (wstrb),
      .dmem_rsp_valid_i (rsp_valid),
      .dmem_rdata_i     (rdata),
      .dmem_rsp_err_i   (rsp_err),
      .result_o         (result),
      .stall_o          (stall),
      .misalign_o       (misalign),
      .bus_err_o        (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      lsu_op    = LSU_NONE;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
   endtask

   // Load with ready in cycle 0, response in cycle 1, result checked in cycle 2.
   task automatic do_load(input string tag, input lsu_op_t op, input logic [63:0] a,
                          input logic [63:0] rd, input logic [63:0] exp);
      lsu_op = op; alu_result = a; mem_read = 1'b1; mem_write = 1'b0; req_ready = 1'b1;
      #1;
      check({tag, "_req_valid"}, 64'(req_valid), 64'd1);
      check({tag, "_stall0"}, 64'(stall), 64'd1);
      check({tag, "_wstrb"}, 64'(wstrb), 64'd0);
      check({tag, "_addr"}, addr, {a[63:3], 3'b000});
      tick();
      req_ready = 1'b0; rsp_valid = 1'b1; rdata = rd;
      #1;
      check({tag, "_stall1"}, 64'(stall), 64'd1);
      check({tag, "_no_req_resp"}, 64'(req_valid), 64'd0);
      tick();
      rsp_valid = 1'b0; rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      #1;
      check({tag, "_stall_done"}, 64'(stall), 64'd0);
      check({tag, "_no_req_done"}, 64'(req_valid), 64'd0);
      check({tag, "_result"}, result, exp);
      tick();
   endtask

   initial begin
      rst = 1'b1; alu_result = 64'h0; store_data = 64'h0; rdata = 64'h0;
      go_idle();
      #2;
      check("reset_stall", 64'(stall), 64'd0);
      check("reset_req_valid", 64'(req_valid), 64'd0);
      alu_result = 64'h1111;
      #1;
      check("reset_result", result, 64'h1111);
      tick();
      rst = 1'b0;
      tick();

      do_load("lb",  LSU_LB,  64'h1003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
      go_idle();
      #1;
      check("idle_after_lb_result", result, 64'h1003);
      do_load("lbu", LSU_LBU, 64'h1003, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
      do_load("lh",  LSU_LH,  64'h100A, 64'h0000_0000_F00D_0000, 64'hFFFF_FFFF_FFFF_F00D);
      do_load("lw",  LSU_LW,  64'h1004, 64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF);
      do_load("lwu", LSU_LWU, 64'h1004, 64'h89AB_CDEF_0000_0000, 64'h0000_0000_89AB_CDEF);
      go_idle();

      // SH with ready held low for three cycles.
      lsu_op = LSU_SH; alu_result = 64'h2006; store_data = 64'h1234_ABCD; mem_write = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_ready = (i == 3);
         #1;
         check("sh_req_valid", 64'(req_valid), 64'd1);
         check("sh_addr", addr, 64'h2000);
         check("sh_wstrb", 64'(wstrb), 64'hC0);
         check("sh_wdata", wdata, 64'hABCD_ABCD_ABCD_ABCD);
         check("sh_we", 64'(we), 64'd1);
         tick();
      end
      req_ready = 1'b0; rsp_valid = 1'b1;
      #1;
      check("sh_resp_stall", 64'(stall), 64'd1);
      tick();
      rsp_valid = 1'b0;
      #1;
      check("sh_done_stall", 64'(stall), 64'd0);
      check("sh_done_result", result, 64'h2006);
      tick();
      go_idle();

      // Misaligned LW.
      lsu_op = LSU_LW; alu_result = 64'h3002; mem_read = 1'b1;
      #1;
      check("mis_pulse", 64'(misalign), 64'd1);
      check("mis_req_valid", 64'(req_valid), 64'd0);
      check("mis_stall", 64'(stall), 64'd0);
      tick();
      go_idle();
      #1;
      check("mis_cleared", 64'(misalign), 64'd0);

      // Timeout after four RESP cycles.
      lsu_op = LSU_LD; alu_result = 64'h4000; mem_read = 1'b1; req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         #1;
         check($sformatf("to_bus_err_c%0d", i), 64'(bus_err), (i == 4) ? 64'd1 : 64'd0);
         check($sformatf("to_stall_c%0d", i), 64'(stall), 64'd1);
         tick();
      end
      check("to_done_result", result, 64'd0);
      check("to_done_bus_err", 64'(bus_err), 64'd0);
      check("to_done_stall", 64'(stall), 64'd0);
      tick();

      // Response error.
      lsu_op = LSU_LD; alu_result = 64'h5008; mem_read = 1'b1; req_ready = 1'b1;
      tick();
      req_ready = 1'b0; rsp_valid = 1'b1; rsp_err = 1'b1; rdata = 64'h0123_4567_89AB_CDEF;
      #1;
      check("err_bus_err", 64'(bus_err), 64'd1);
      tick();
      rsp_valid = 1'b0; rsp_err = 1'b0;
      #1;
      check("err_done_bus_err", 64'(bus_err), 64'd0);
      check("err_done_result", result, 64'h0123_4567_89AB_CDEF);
      tick();
      go_idle();

      // Back-to-back SD then LD.
      lsu_op = LSU_SD; alu_result = 64'h6000; store_data = 64'h1122_3344_5566_7788;
      mem_write = 1'b1; req_ready = 1'b1;
      #1;
      check("sd_wstrb", 64'(wstrb), 64'hFF);
      check("sd_wdata", wdata, 64'h1122_3344_5566_7788);
      tick();
      req_ready = 1'b0; rsp_valid = 1'b1;
      tick();
      rsp_valid = 1'b0; req_ready = 1'b1;
      #1;
      check("sd_done_no_req", 64'(req_valid), 64'd0);
      check("sd_done_result", result, 64'h6000);
      tick();
      mem_write = 1'b0;
      do_load("ld", LSU_LD, 64'h6008, 64'hCAFE_F00D_1234_5678, 64'hCAFE_F00D_1234_5678);
      go_idle();

      // Asynchronous reset in the middle of RESP.
      lsu_op = LSU_LW; alu_result = 64'h7000; mem_read = 1'b1; req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      #1;
      check("rst_pre_stall", 64'(stall), 64'd1);
      #1;
      rst = 1'b1; mem_read = 1'b0; lsu_op = LSU_NONE;
      #1;
      check("rst_async_stall", 64'(stall), 64'd0);
      check("rst_async_req", 64'(req_valid), 64'd0);
      check("rst_async_result", result, 64'h7000);
      tick();
      rst = 1'b0;
      tick();
      check("rst_after_stall", 64'(stall), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
